// File: rtl/sram_access_arbiter_if.sv
// Request-side bundle between the capture writer / read port and the SRAM arbiter.
// master = requesters, slave = arbiter.
interface sram_access_arbiter_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              busy;

  modport master (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr,
    input  wr_ack, rd_ack, rd_data, rd_valid, busy
  );

  modport slave (
    input  wr_req, wr_addr, wr_data, rd_req, rd_addr,
    output wr_ack, rd_ack, rd_data, rd_valid, busy
  );
endinterface

// File: rtl/sram_access_arbiter.sv
// Two-requester arbiter for the external 16-bit async SRAM: writer-priority with a reader starvation guard,
// fixed setup/strobe access sequencing. Optional grant statistics under `ARB_STATS_EN.
module sram_access_arbiter #(
  parameter int ADDR_W          = 20,
  parameter int DATA_W          = 16,
  parameter int RD_STARVE_LIMIT = 4
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset,
  sram_access_arbiter_if.slave req,
  inout  wire  [DATA_W-1:0]    sram_DQ,
  output logic [ADDR_W-1:0]    sram_ADDR,
  output logic                 sram_LB_N,
  output logic                 sram_UB_N,
  output logic                 sram_CE_N,
  output logic                 sram_OE_N,
  output logic                 sram_WE_N
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]          stat_wr_cnt,
  output logic [15:0]          stat_rd_cnt,
  output logic [15:0]          stat_conflict_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    WR_SETUP,
    WR_STROBE,
    RD_SETUP,
    RD_SAMPLE
  } state_t;

  state_t            state;
  logic [3:0]        streak;
  logic [DATA_W-1:0] dq_out;
  logic              dq_oe;
  logic              grant_wr;
  logic              grant_rd;

  function automatic logic [3:0] sat_inc_streak(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  function automatic logic [15:0] sat_inc_stat(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Only the registered enable controls the bus, so DQ can never glitch on during a read.
  assign sram_DQ = dq_oe ? dq_out : {DATA_W{1'bz}};

  always_comb begin
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (req.wr_req && req.rd_req) begin
      if (streak >= 4'(RD_STARVE_LIMIT)) grant_rd = 1'b1;
      else                               grant_wr = 1'b1;
    end else begin
      grant_wr = req.wr_req;
      grant_rd = req.rd_req;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state        <= IDLE;
      streak       <= '0;
      sram_ADDR    <= '0;
      dq_out       <= '0;
      dq_oe        <= 1'b0;
      sram_CE_N    <= 1'b1;
      sram_OE_N    <= 1'b1;
      sram_WE_N    <= 1'b1;
      sram_LB_N    <= 1'b1;
      sram_UB_N    <= 1'b1;
      req.wr_ack   <= 1'b0;
      req.rd_ack   <= 1'b0;
      req.rd_valid <= 1'b0;
      req.rd_data  <= '0;
      req.busy     <= 1'b0;
    end else begin
      req.wr_ack   <= 1'b0;
      req.rd_ack   <= 1'b0;
      req.rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_wr) begin
            state      <= WR_SETUP;
            streak     <= sat_inc_streak(streak);
            sram_ADDR  <= req.wr_addr;
            dq_out     <= req.wr_data;
            dq_oe      <= 1'b1;
            sram_CE_N  <= 1'b0;
            sram_LB_N  <= 1'b0;
            sram_UB_N  <= 1'b0;
            req.wr_ack <= 1'b1;
            req.busy   <= 1'b1;
          end else if (grant_rd) begin
            state      <= RD_SETUP;
            streak     <= '0;
            sram_ADDR  <= req.rd_addr;
            sram_CE_N  <= 1'b0;
            sram_OE_N  <= 1'b0;
            sram_LB_N  <= 1'b0;
            sram_UB_N  <= 1'b0;
            req.rd_ack <= 1'b1;
            req.busy   <= 1'b1;
          end else begin
            // No grant implies the writer is idle, which breaks its streak.
            streak <= '0;
          end
        end
        WR_SETUP: begin
          state     <= WR_STROBE;
          sram_WE_N <= 1'b0;
        end
        WR_STROBE: begin
          state     <= IDLE;
          sram_WE_N <= 1'b1;
          sram_CE_N <= 1'b1;
          sram_LB_N <= 1'b1;
          sram_UB_N <= 1'b1;
          dq_oe     <= 1'b0;
          req.busy  <= 1'b0;
        end
        RD_SETUP: begin
          state <= RD_SAMPLE;
        end
        RD_SAMPLE: begin
          state        <= IDLE;
          req.rd_data  <= sram_DQ;
          req.rd_valid <= 1'b1;
          sram_CE_N    <= 1'b1;
          sram_OE_N    <= 1'b1;
          sram_LB_N    <= 1'b1;
          sram_UB_N    <= 1'b1;
          req.busy     <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      stat_wr_cnt       <= '0;
      stat_rd_cnt       <= '0;
      stat_conflict_cnt <= '0;
    end else if (state == IDLE) begin
      if (grant_wr)                 stat_wr_cnt       <= sat_inc_stat(stat_wr_cnt);
      if (grant_rd)                 stat_rd_cnt       <= sat_inc_stat(stat_rd_cnt);
      if (req.wr_req && req.rd_req) stat_conflict_cnt <= sat_inc_stat(stat_conflict_cnt);
    end
  end
`endif

endmodule
